emif_access_seq: RTL and testbench
==================================

// Module: emif_access_seq
// PURPOSE
// Sequences asynchronous MCU EMIF slave accesses in the 400 MHz fabric domain.
// - Detects the falling edge of the chip-select/CAS strobe.
// - Samples address, data and direction.
// - Issues exactly one read request or write strobe to the internal register bank.
// - For reads, drives emif_data_out with emif_data_oe for a fixed window.
// Sits between the EMIF pads (tri-state control) and the register bank.
// PARAMETERS
// AW          16  EMIF address width
// DW          16  EMIF data width
// SAMPLE_DLY  4   clk cycles from cas_fall to address/data sampling (>=1)
// DRIVE_CYC   24  clk cycles emif_data_oe is held per read (60 ns @ 400 MHz, >=1)
// RD_TIMEOUT  16  clk cycles to wait for reg_rd_valid before the error fallback (>=1)
// PORTS
// clk             in   1   400 MHz system clock
// rst_n           in   1   reset, asynchronous, active-low
// cas_in          in   1   EMIF CAS/CS strobe, active-low, asynchronous
// we_logic        in   1   access direction, 1 = MCU read, 0 = MCU write
// emif_addr_in    in   AW  EMIF address bus
// emif_data_in    in   DW  EMIF write data
// emif_data_out   out  DW  read data returned to MCU
// emif_data_oe    out  1   1 = FPGA drives EMIF data pads
// reg_rd_req      out  1   1-cycle read request to register bank
// reg_rd_addr     out  AW  read address, valid while reg_rd_req = 1
// reg_rd_data     in   DW  register bank read data
// reg_rd_valid    in   1   reg_rd_data valid (1 cycle)
// reg_wr_en       out  1   1-cycle write strobe
// reg_wr_addr     out  AW  write address, valid while reg_wr_en = 1
// reg_wr_data     out  DW  write data, valid while reg_wr_en = 1
// busy            out  1   1 whenever state != IDLE
// err_timeout     out  1   1-cycle pulse when a read times out
// err_overrun     out  1   1-cycle pulse when a cas falling edge arrives outside IDLE
// BEHAVIOUR
// Reset: all outputs are 0; emif_data_out = 0; state = IDLE; counters = 0.
// - Reset mid-access aborts immediately. No strobe is issued afterwards.
// Sync: cas_in passes through a 2-flop synchronizer (c0, c1).
// - cas_fall = c1 & ~c0 (one cycle).
// - Other inputs are sampled raw; the MCU holds them stable by the sample point.
// FSM, with T = the cycle in which cas_fall = 1:
// - IDLE: on cas_fall, go to SAMPLE and set cnt = 1. Other cas_fall edges pulse err_overrun.
// - SAMPLE: cnt increments each cycle. When cnt == SAMPLE_DLY (cycle T+SAMPLE_DLY),
//   latch addr, data and we_logic.
//   - Read: the next cycle, T+SAMPLE_DLY+1, reg_rd_req = 1 for 1 cycle; state = RD_WAIT.
//   - Write: the next cycle, reg_wr_en = 1 for 1 cycle; state = RECOVER.
// - RD_WAIT: a wait counter starts at 0 in the reg_rd_req cycle.
//   - If reg_rd_valid = 1: emif_data_out <= reg_rd_data; emif_data_oe = 1 from the next cycle;
//     state = RD_DRIVE. reg_rd_valid in the same cycle as reg_rd_req is accepted.
//   - If the counter reaches RD_TIMEOUT with no valid: emif_data_out <= all ones;
//     err_timeout pulse; state = RD_DRIVE.
// - RD_DRIVE: emif_data_oe is held for exactly DRIVE_CYC cycles, then cleared; state = RECOVER.
//   - emif_data_out keeps its value until the next read load.
// - RECOVER: stay until c0 == 1 (CAS released), then go to IDLE.
//   - cas_in already high on entry: RECOVER -> IDLE in 1 cycle.
// Short CAS (released before the sample point): the access still completes on the latched sample.
// busy = (state != IDLE).
// At most one reg_rd_req or reg_wr_en per cas_fall. Never both in the same access.
// TESTING
// 1 Read, reg_rd_valid same cycle as req, data 16'hA5C3 -> req at T+5, oe high 24 cycles, out=A5C3
// 2 Read, valid 3 cycles after req, addr 16'h0040 -> reg_rd_addr=0040, oe rises 1 cycle after valid
// 3 Read, valid never asserted -> err_timeout pulse at req+16, out=FFFF, oe 24 cycles
// 4 Write addr 16'h0012 data 16'h1234 -> single reg_wr_en at T+5 with 0012/1234, oe stays 0
// 5 Second cas fall during RD_DRIVE -> err_overrun pulse, no second req, first read completes
// 6 rst_n low mid RD_DRIVE -> oe=0 and busy=0 immediately; next access behaves as scenario 1

Source files
------------

// File: rtl/emif_access_seq.sv
// -----------------------------------------------------------------------------
// emif_access_seq
//
// Turns one asynchronous MCU EMIF slave access into exactly one register-bank
// transaction, running in the 400 MHz clk domain.
// - A CAS/CS falling edge is detected after a 2-flop synchronizer.
// - Address, data and direction are sampled SAMPLE_DLY cycles later.
// - A read issues reg_rd_req. The returned data is driven onto the EMIF data
//   pads for DRIVE_CYC cycles.
// - A write issues a single reg_wr_en strobe.
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for a synchronized CAS falling edge
//   S_SAMPLE   | counting up to the address/data sample point
//   S_RD_WAIT  | read request issued, waiting for reg_rd_valid or timeout
//   S_RD_DRIVE | emif_data_oe asserted, read data presented to the MCU
//   S_RECOVER  | access done, waiting for CAS to be released
//
// Ports
//   clk, rst_n              400 MHz clock, async active-low reset
//   cas_in                  EMIF CAS/CS strobe (active-low, asynchronous)
//   we_logic                direction, 1 = MCU read, 0 = MCU write
//   emif_addr_in            EMIF address bus
//   emif_data_in            EMIF write data
//   emif_data_out           read data returned to the MCU
//   emif_data_oe            pad output enable for the data bus
//   reg_rd_req              read request to the register bank (1 cycle)
//   reg_rd_addr             read address
//   reg_rd_data             read data from the register bank
//   reg_rd_valid            reg_rd_data qualifier
//   reg_wr_en               write strobe (1 cycle)
//   reg_wr_addr             write address
//   reg_wr_data             write data
//   busy                    state != S_IDLE
//   err_timeout             read timed out (1 cycle)
//   err_overrun             CAS falling edge seen outside S_IDLE (1 cycle)
// -----------------------------------------------------------------------------
module emif_access_seq #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int SAMPLE_DLY = 4,
  parameter int DRIVE_CYC  = 24,
  parameter int RD_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cas_in,
  input  logic          we_logic,
  input  logic [AW-1:0] emif_addr_in,
  input  logic [DW-1:0] emif_data_in,
  output logic [DW-1:0] emif_data_out,
  output logic          emif_data_oe,
  output logic          reg_rd_req,
  output logic [AW-1:0] reg_rd_addr,
  input  logic [DW-1:0] reg_rd_data,
  input  logic          reg_rd_valid,
  output logic          reg_wr_en,
  output logic [AW-1:0] reg_wr_addr,
  output logic [DW-1:0] reg_wr_data,
  output logic          busy,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int SW  = $clog2(SAMPLE_DLY + 1);
  localparam int WW  = $clog2(RD_TIMEOUT + 1);
  localparam int DCW = $clog2(DRIVE_CYC + 1);

  localparam logic [SW-1:0]  SMP_TC   = SW'(SAMPLE_DLY);
  // The wait counter is 0 in the request cycle. The transition out of
  // S_RD_WAIT is registered, so the last cycle still waiting for valid is
  // RD_TIMEOUT-1. err_timeout therefore shows up RD_TIMEOUT cycles after
  // the request cycle.
  localparam logic [WW-1:0]  WAIT_TC  = WW'(RD_TIMEOUT - 1);
  // The drive timer counts down to zero, and oe drops on the edge after
  // the timer reads zero. Loading DRIVE_CYC-1 gives exactly DRIVE_CYC
  // cycles with oe high.
  localparam logic [DCW-1:0] DRV_LOAD = DCW'(DRIVE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_RD_WAIT,
    S_RD_DRIVE,
    S_RECOVER
  } state_t;

  state_t state_q, state_d;

  logic           c0, c1;
  logic           cas_fall;

  logic [SW-1:0]  smp_cnt_q, smp_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DCW-1:0] drv_cnt_q, drv_cnt_d;

  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           oe_q, oe_d;
  logic           rd_req_q, rd_req_d;
  logic           wr_en_q, wr_en_d;
  logic           err_to_q, err_to_d;
  logic           err_ov_q, err_ov_d;

  // Reset to 0 so that a CAS held low through reset release is not
  // mistaken for a new falling edge. A fall needs c1 = 1 and c0 = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      c0 <= cas_in;
      c1 <= c0;
    end
  end

  assign cas_fall = c1 & ~c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      smp_cnt_q  <= '0;
      wait_cnt_q <= '0;
      drv_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      drv_cnt_q  <= drv_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      rd_req_q   <= rd_req_d;
      wr_en_q    <= wr_en_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    wait_cnt_d = wait_cnt_q;
    drv_cnt_d  = drv_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    rd_req_d   = 1'b0;
    wr_en_d    = 1'b0;
    err_to_d   = 1'b0;
    err_ov_d   = cas_fall && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (cas_fall) begin
          smp_cnt_d = SW'(1);
          state_d   = S_SAMPLE;
        end
      end

      // The direction is taken from the raw input at the sample point,
      // together with address and data. After that, a CAS that has already
      // been released cannot change the outcome of the access.
      S_SAMPLE: begin
        if (smp_cnt_q == SMP_TC) begin
          addr_d = emif_addr_in;
          data_d = emif_data_in;
          if (we_logic) begin
            rd_req_d   = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_RD_WAIT;
          end else begin
            wr_en_d = 1'b1;
            state_d = S_RECOVER;
          end
        end else begin
          smp_cnt_d = smp_cnt_q + SW'(1);
        end
      end

      S_RD_WAIT: begin
        if (reg_rd_valid) begin
          dout_d    = reg_rd_data;
          oe_d      = 1'b1;
          drv_cnt_d = DRV_LOAD;
          state_d   = S_RD_DRIVE;
        end else if (wait_cnt_q == WAIT_TC) begin
          dout_d    = '1;
          err_to_d  = 1'b1;
          oe_d      = 1'b1;
          drv_cnt_d = DRV_LOAD;
          state_d   = S_RD_DRIVE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end

      S_RD_DRIVE: begin
        if (drv_cnt_q == '0) begin
          oe_d    = 1'b0;
          state_d = S_RECOVER;
        end else begin
          drv_cnt_d = drv_cnt_q - DCW'(1);
        end
      end

      S_RECOVER: begin
        if (c0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  assign emif_data_out = dout_q;
  assign emif_data_oe  = oe_q;
  assign reg_rd_req    = rd_req_q;
  assign reg_rd_addr   = addr_q;
  assign reg_wr_en     = wr_en_q;
  assign reg_wr_addr   = addr_q;
  assign reg_wr_data   = data_q;
  assign busy          = (state_q != S_IDLE);
  assign err_timeout   = err_to_q;
  assign err_overrun   = err_ov_q;

endmodule

// File: tb/tb_emif_access_seq.sv
module tb_emif_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cas_in;
  logic        we_logic;
  logic [15:0] emif_addr_in;
  logic [15:0] emif_data_in;
  logic [15:0] emif_data_out;
  logic        emif_data_oe;
  logic        reg_rd_req;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        reg_rd_valid;
  logic        reg_wr_en;
  logic [15:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        busy;
  logic        err_timeout;
  logic        err_overrun;

  emif_access_seq #(
    .AW(16), .DW(16), .SAMPLE_DLY(4), .DRIVE_CYC(24), .RD_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cas_in(cas_in), .we_logic(we_logic),
    .emif_addr_in(emif_addr_in), .emif_data_in(emif_data_in),
    .emif_data_out(emif_data_out), .emif_data_oe(emif_data_oe),
    .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    int          len;
  } exp_t;

  exp_t q_rd[$];
  exp_t q_wr[$];
  exp_t q_to[$];
  exp_t q_ov[$];
  exp_t q_drv[$];

  // register bank responder: rsp_delay < 0 means never answer
  int          rsp_delay = 0;
  logic [15:0] rsp_data  = '0;
  int          rsp_cnt   = -1;

  always @(negedge clk) begin
    reg_rd_valid = 1'b0;
    if (!rst_n) begin
      rsp_cnt = -1;
    end else begin
      if (reg_rd_req && rsp_delay >= 0) rsp_cnt = rsp_delay;
      if (rsp_cnt == 0) begin
        reg_rd_valid = 1'b1;
        reg_rd_data  = rsp_data;
        rsp_cnt      = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
      end
    end
  end

  // monitor / scoreboard
  logic        prev_oe = 1'b0;
  int          drv_start = 0;
  logic [15:0] drv_data = '0;
  logic        drv_stable = 1'b1;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe = 1'b0;
    end else begin
      if (reg_rd_req) begin
        checks++;
        if (q_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_req unexpected: cycle %0d addr %h, required none", cyc, reg_rd_addr);
        end else begin
          m_e = q_rd.pop_front();
          if (cyc != m_e.cyc || reg_rd_addr !== m_e.addr) begin
            errors++;
            $display("FAIL rd_req: cycle %0d addr %h, required cycle %0d addr %h",
                     cyc, reg_rd_addr, m_e.cyc, m_e.addr);
          end
        end
      end
      if (reg_wr_en) begin
        checks++;
        if (q_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_en unexpected: cycle %0d addr %h data %h, required none",
                   cyc, reg_wr_addr, reg_wr_data);
        end else begin
          m_e = q_wr.pop_front();
          if (cyc != m_e.cyc || reg_wr_addr !== m_e.addr || reg_wr_data !== m_e.data) begin
            errors++;
            $display("FAIL wr_en: cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                     cyc, reg_wr_addr, reg_wr_data, m_e.cyc, m_e.addr, m_e.data);
          end
        end
      end
      if (err_timeout) begin
        checks++;
        if (q_to.size() == 0) begin
          errors++;
          $display("FAIL err_timeout unexpected: cycle %0d, required none", cyc);
        end else begin
          m_e = q_to.pop_front();
          if (cyc != m_e.cyc) begin
            errors++;
            $display("FAIL err_timeout: cycle %0d, required %0d", cyc, m_e.cyc);
          end
        end
      end
      if (err_overrun) begin
        checks++;
        if (q_ov.size() == 0) begin
          errors++;
          $display("FAIL err_overrun unexpected: cycle %0d, required none", cyc);
        end else begin
          m_e = q_ov.pop_front();
          if (cyc != m_e.cyc) begin
            errors++;
            $display("FAIL err_overrun: cycle %0d, required %0d", cyc, m_e.cyc);
          end
        end
      end
      if (emif_data_oe && !prev_oe) begin
        drv_start  = cyc;
        drv_data   = emif_data_out;
        drv_stable = 1'b1;
      end else if (emif_data_oe && emif_data_out !== drv_data) begin
        drv_stable = 1'b0;
      end
      if (!emif_data_oe && prev_oe) begin
        checks++;
        if (q_drv.size() == 0) begin
          errors++;
          $display("FAIL oe window unexpected: start %0d data %h, required none", drv_start, drv_data);
        end else begin
          m_e = q_drv.pop_front();
          if (drv_start != m_e.cyc || (cyc - drv_start) != m_e.len ||
              drv_data !== m_e.data || !drv_stable) begin
            errors++;
            $display("FAIL oe window: start %0d len %0d data %h stable %0b, required start %0d len %0d data %h stable 1",
                     drv_start, cyc - drv_start, drv_data, drv_stable, m_e.cyc, m_e.len, m_e.data);
          end
        end
      end
      prev_oe = emif_data_oe;
    end
  end

  function automatic exp_t mk(input int c, input logic [15:0] a, input logic [15:0] d, input int l);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d; e.len = l;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // cas falls just after the next posedge; T is the cycle where cas_fall is seen
  task automatic start_access(input logic rd, input logic [15:0] a, input logic [15:0] d,
                              output int t);
    @(negedge clk);
    we_logic     = rd;
    emif_addr_in = a;
    emif_data_in = d;
    cas_in       = 1'b0;
    t = cyc + 1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || emif_data_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || emif_data_oe) begin
      errors++;
      $display("FAIL %s idle timeout: busy %0b oe %0b, required 0 0", name, busy, emif_data_oe);
    end
    repeat (3) @(negedge clk);
  endtask

  int t;
  int t2;

  initial begin
    rst_n        = 1'b0;
    cas_in       = 1'b1;
    we_logic     = 1'b0;
    emif_addr_in = '0;
    emif_data_in = '0;
    reg_rd_data  = '0;
    reg_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy",     {15'd0, busy},         16'h0000);
    chk("reset oe",       {15'd0, emif_data_oe}, 16'h0000);
    chk("reset data_out", emif_data_out,         16'h0000);
    chk("reset rd_req",   {15'd0, reg_rd_req},   16'h0000);
    chk("reset wr_en",    {15'd0, reg_wr_en},    16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: read, valid in the request cycle
    rsp_delay = 0; rsp_data = 16'hA5C3;
    start_access(1'b1, 16'h0100, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0100, 16'h0, 0));
    q_drv.push_back(mk(t + 6, 16'h0, 16'hA5C3, 24));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_idle("s1");

    // 2: read, valid 3 cycles after request
    rsp_delay = 3; rsp_data = 16'h5A3C;
    start_access(1'b1, 16'h0040, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0040, 16'h0, 0));
    q_drv.push_back(mk(t + 9, 16'h0, 16'h5A3C, 24));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_idle("s2");

    // 3: read, never valid -> timeout fallback
    rsp_delay = -1;
    start_access(1'b1, 16'h0077, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0077, 16'h0, 0));
    q_to.push_back(mk(t + 21, 16'h0, 16'h0, 0));
    q_drv.push_back(mk(t + 21, 16'h0, 16'hFFFF, 24));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_idle("s3");

    // 4: write
    rsp_delay = 0;
    start_access(1'b0, 16'h0012, 16'h1234, t);
    q_wr.push_back(mk(t + 5, 16'h0012, 16'h1234, 0));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_idle("s4");

    // 5: second cas fall during RD_DRIVE
    rsp_delay = 0; rsp_data = 16'h0BEE;
    start_access(1'b1, 16'h0200, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0200, 16'h0, 0));
    q_drv.push_back(mk(t + 6, 16'h0, 16'h0BEE, 24));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_cyc(t + 11);
    start_access(1'b1, 16'h0300, 16'h0000, t2);
    q_ov.push_back(mk(t2 + 1, 16'h0, 16'h0, 0));
    wait_cyc(t2 + 3); cas_in = 1'b1;
    wait_idle("s5");

    // 6: reset in the middle of RD_DRIVE
    rsp_delay = 0; rsp_data = 16'hC0DE;
    start_access(1'b1, 16'h0500, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0500, 16'h0, 0));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_cyc(t + 15);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset oe",   {15'd0, emif_data_oe}, 16'h0000);
    chk("mid reset busy", {15'd0, busy},         16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    rsp_delay = 0; rsp_data = 16'hA5C3;
    start_access(1'b1, 16'h0100, 16'h0000, t);
    q_rd.push_back(mk(t + 5, 16'h0100, 16'h0, 0));
    q_drv.push_back(mk(t + 6, 16'h0, 16'hA5C3, 24));
    wait_cyc(t + 8); cas_in = 1'b1;
    wait_idle("s6");

    chk("pending rd",  16'(q_rd.size()),  16'h0000);
    chk("pending wr",  16'(q_wr.size()),  16'h0000);
    chk("pending to",  16'(q_to.size()),  16'h0000);
    chk("pending ov",  16'(q_ov.size()),  16'h0000);
    chk("pending drv", 16'(q_drv.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
